// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared session states, core state codes and product codes
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SELECT,
        S_PAY,
        S_ABORT,
        S_DONE
    } sess_state_t;

    localparam logic [3:0] VM_IDLE   = 4'd0;
    localparam logic [3:0] VM_PSEL   = 4'd1;
    localparam logic [3:0] VM_PAY_LO = 4'd2;
    localparam logic [3:0] VM_PAY_HI = 4'd8;
    localparam logic [3:0] VM_DISP   = 4'd9;

    // Code 7 is deliberately unassigned; the core rejects it by returning to idle.
    localparam logic [2:0] PROD_WATER    = 3'd0;
    localparam logic [2:0] PROD_SODA     = 3'd1;
    localparam logic [2:0] PROD_SANDWICH = 3'd2;
    localparam logic [2:0] PROD_JUICE    = 3'd3;
    localparam logic [2:0] PROD_CHIPS    = 3'd4;
    localparam logic [2:0] PROD_CANDY    = 3'd5;
    localparam logic [2:0] PROD_COFFEE   = 3'd6;
    localparam logic [2:0] PROD_INVALID  = 3'd7;

    function automatic logic vm_awaiting_pay(input logic [3:0] s);
        return (s >= VM_PAY_LO) && (s <= VM_PAY_HI);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        logic [PTR_W-1:0] k;
        k      = '0;
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = PTR_W'((int'(ptr) + i) % N_REQ);
            if (en && !valid && req[k]) begin
                grant[k] = 1'b1;
                winner   = k;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_session_arbiter.sv
// rtl/vend_session_arbiter.sv - shares one vending core among N_REQ panels, one session at a time
module vend_session_arbiter
    import vend_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] req_product,
    input  logic [7*N_REQ-1:0] req_amount,
    input  logic [N_REQ-1:0]   req_online,
    input  logic [N_REQ-1:0]   req_cancel,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               dispensed,
    output logic [7:0]         change_out,
    output logic               busy,
    output logic               vm_start,
    output logic               vm_cancel,
    output logic               vm_online,
    output logic [2:0]         vm_product,
    output logic [6:0]         vm_amount,
    input  logic [3:0]         vm_state,
    input  logic               vm_dispense,
    input  logic [7:0]         vm_change
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    sess_state_t      state, state_next;
    logic [N_REQ-1:0] arb_grant;
    logic [PW-1:0]    arb_winner;
    logic             arb_valid;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win_idx;
    logic [2:0]       lat_product;
    logic [6:0]       lat_amount;
    logic             lat_online;
    logic [CW-1:0]    pay_cnt;
    logic [7:0]       res_change;
    logic             res_disp;
    logic             take_grant;
    logic             cap_dispense;
    logic             cap_refund;
    logic             win_quit;
    logic [7:0]       refund_value;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PW)) u_rr_arbiter (
        .req    (req),
        .ptr    (ptr),
        .en     (state == S_IDLE),
        .grant  (arb_grant),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    assign win_quit     = req_cancel[win_idx] | ~req[win_idx];
    assign refund_value = lat_online ? 8'd0 : {1'b0, lat_amount};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority inside PAY: dispense beats cancel, which beats core-idle and timeout.
    always_comb begin
        state_next   = state;
        take_grant   = 1'b0;
        cap_dispense = 1'b0;
        cap_refund   = 1'b0;
        vm_start     = 1'b0;
        vm_cancel    = 1'b0;
        vm_online    = 1'b0;
        vm_product   = 3'd0;
        vm_amount    = 7'd0;
        case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    take_grant = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                vm_start = 1'b1;
                if (win_quit)
                    state_next = S_ABORT;
                else if (vm_state == VM_PSEL)
                    state_next = S_SELECT;
            end
            S_SELECT: begin
                vm_product = lat_product;
                if (win_quit) begin
                    state_next = S_ABORT;
                end else if (vm_awaiting_pay(vm_state)) begin
                    state_next = S_PAY;
                end else if (vm_state == VM_IDLE) begin
                    cap_refund = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_PAY: begin
                vm_amount = lat_amount;
                vm_online = lat_online;
                if (vm_dispense) begin
                    cap_dispense = 1'b1;
                    state_next   = S_DONE;
                end else if (win_quit) begin
                    state_next = S_ABORT;
                end else if (vm_state == VM_IDLE) begin
                    cap_refund = 1'b1;
                    state_next = S_DONE;
                end else if (pay_cnt == CW'(TIMEOUT - 1)) begin
                    state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                vm_cancel = 1'b1;
                if (vm_state == VM_IDLE) begin
                    cap_refund = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            done        <= '0;
            dispensed   <= 1'b0;
            change_out  <= 8'd0;
            busy        <= 1'b0;
            ptr         <= '0;
            win_idx     <= '0;
            lat_product <= 3'd0;
            lat_amount  <= 7'd0;
            lat_online  <= 1'b0;
            pay_cnt     <= '0;
            res_change  <= 8'd0;
            res_disp    <= 1'b0;
        end else begin
            busy       <= (state_next != S_IDLE);
            done       <= '0;
            dispensed  <= 1'b0;
            change_out <= 8'd0;
            pay_cnt    <= (state == S_PAY) ? pay_cnt + 1'b1 : '0;
            if (take_grant) begin
                grant       <= arb_grant;
                win_idx     <= arb_winner;
                ptr         <= (arb_winner == PW'(N_REQ - 1)) ? '0 : arb_winner + 1'b1;
                lat_product <= req_product[3*int'(arb_winner) +: 3];
                lat_amount  <= req_amount[7*int'(arb_winner) +: 7];
                lat_online  <= req_online[arb_winner];
                res_change  <= 8'd0;
                res_disp    <= 1'b0;
            end
            if (cap_dispense) begin
                res_change <= vm_change;
                res_disp   <= 1'b1;
            end
            if (cap_refund) begin
                res_change <= refund_value;
                res_disp   <= 1'b0;
            end
            if (state == S_DONE) begin
                done       <= grant;
                dispensed  <= res_disp;
                change_out <= res_change;
                grant      <= '0;
            end
        end
    end

endmodule
